msrv32_mem_arbiter: RTL and testbench
=====================================

# msrv32_mem_arbiter

Arbitrates the single external memory port of the msrv32 core between instruction fetch (IF) and the load/store path (LS) that the decoder drives through its mem_wr_req/load/misaligned outputs. Owns a small FSM that launches one bus transaction at a time, holds it until the memory acknowledges, and returns data to the winner. Sits between the fetch unit, the decoder/LSU and the memory interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive LS grants tolerated while IF waits (fairness build only)
- ms_riscv32_mp_clk_in  in  1  clock, rising edge
- ms_riscv32_mp_rst_n_in  in  1  reset, asynchronous, active-low
- if_req_in  in  1  fetch request; held until if_gnt_out
- if_addr_in  in  ADDR_W  fetch address
- if_gnt_out  out  1  one-cycle pulse: fetch request accepted
- if_rvalid_out  out  1  one-cycle pulse: if_rdata_out valid
- if_rdata_out  out  DATA_W  fetched word
- ls_req_in  in  1  load/store request; held until ls_gnt_out
- ls_we_in  in  1  1 = store (decoder mem_wr_req), 0 = load
- ls_misaligned_in  in  1  decoder misaligned_load | misaligned_store
- trap_taken_in  in  1  trap in progress; blocks new LS launch
- ls_addr_in  in  ADDR_W  load/store address
- ls_wdata_in  in  DATA_W  store data
- ls_wr_mask_in  in  DATA_W/8  byte strobes
- ls_gnt_out  out  1  one-cycle pulse: LS request consumed
- ls_rvalid_out  out  1  one-cycle pulse: load data / store completion
- ls_rdata_out  out  DATA_W  load data; 0 for stores
- ls_err_out  out  1  one-cycle pulse: misaligned request dropped
- mem_req_out  out  1  bus request, held until mem_ack_in
- mem_we_out  out  1  bus write enable
- mem_addr_out  out  ADDR_W  bus address
- mem_wdata_out  out  DATA_W  bus write data
- mem_wr_mask_out  out  DATA_W/8  bus byte strobes
- mem_ack_in  in  1  bus completion; mem_rdata_in valid this cycle
- mem_rdata_in  in  DATA_W  bus read data
- busy_out  out  1  state != IDLE

## Operation
- States: IDLE, IF_WAIT, LS_WAIT.
- IDLE arbitration on sampled requests: LS wins over IF unless fairness forces IF. LS launches only if ~ls_misaligned_in & ~trap_taken_in.
- Misaligned LS in IDLE: no bus cycle; next cycle ls_gnt_out=1 and ls_err_out=1; stays IDLE. IF request in the same cycle is arbitrated normally.
- trap_taken_in=1 in IDLE: LS not launched (held), IF may win.
- Launch: registers mem_* from winner, mem_req_out=1, winner gnt pulse, go to IF_WAIT/LS_WAIT.
- *_WAIT: mem_* stable; on mem_ack_in: mem_req_out drops next cycle, winner rvalid pulses next cycle with rdata captured from mem_rdata_in (0 for stores), go IDLE.
- mem_ack_in in IDLE ignored. Transactions in flight are never aborted (trap_taken_in has no effect in WAIT).
- Reset (any time, incl. mid-transaction): all outputs 0, state IDLE, starve counter 0.

## Timing
- Request sampled at edge N → mem_req_out and gnt high from N+1.
- Ack at earliest N+1 → rvalid and rdata at N+2; next launch earliest N+3 (req sampled N+2).
- Throughput: one transaction per 2 cycles minimum with zero-wait memory.
- gnt and rvalid never coincide for one requester; IF and LS outputs never pulse same cycle except misaligned-drop plus IF launch.

## Configuration
- MSRV32_ARB_FAIRNESS_EN defined: counter of consecutive LS launches while if_req_in=1; at STARVE_LIMIT, next IDLE arbitration grants IF; counter clears on IF launch or when if_req_in=0. Width clog2(STARVE_LIMIT+1), saturating.
- Undefined: fixed LS priority, no counter.

## Structure
- Shared package msrv32_pkg: state encoding (IDLE=2'd0, IF_WAIT=2'd1, LS_WAIT=2'd2), ADDR_W/DATA_W defaults.
- Sub-module msrv32_arb_starve_ctr (counter + force_if output), instantiated only under MSRV32_ARB_FAIRNESS_EN.

## Test plan
- Reset: rst_n low mid LS_WAIT → all outputs 0 immediately; after release busy_out=0, next if_req launches cleanly.
- Single fetch addr 0x100, ack one cycle after mem_req, rdata 0xDEADBEEF → if_gnt at N+1, if_rvalid with 0xDEADBEEF at N+2.
- Simultaneous IF/LS, store 0x200 wdata 0x55 mask 4'b0011 → LS first (mem_we_out=1, ls_rdata_out=0), IF launched after.
- Misaligned load addr 0x201 → ls_gnt+ls_err pulse, mem_req_out stays 0.
- trap_taken_in=1 with LS and IF pending → IF launches, LS held until trap drops.
- Fairness build, STARVE_LIMIT=4, continuous LS+IF requests → pattern LS×4 then IF; without macro IF never granted.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared msrv32 arbiter definitions: FSM state encoding and default bus widths.
package msrv32_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_WAIT = 2'd1;
  localparam logic [1:0] LS_WAIT = 2'd2;

endpackage

// File: rtl/msrv32_mem_arbiter_if.sv
// Arbiter bus bundle: fetch port, load/store port and the external memory port.
// slave = arbiter view, master = requesters/memory view.
interface msrv32_mem_arbiter_if import msrv32_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic                  if_req_in;
  logic [ADDR_W-1:0]     if_addr_in;
  logic                  if_gnt_out;
  logic                  if_rvalid_out;
  logic [DATA_W-1:0]     if_rdata_out;

  logic                  ls_req_in;
  logic                  ls_we_in;
  logic                  ls_misaligned_in;
  logic                  trap_taken_in;
  logic [ADDR_W-1:0]     ls_addr_in;
  logic [DATA_W-1:0]     ls_wdata_in;
  logic [DATA_W/8-1:0]   ls_wr_mask_in;
  logic                  ls_gnt_out;
  logic                  ls_rvalid_out;
  logic [DATA_W-1:0]     ls_rdata_out;
  logic                  ls_err_out;

  logic                  mem_req_out;
  logic                  mem_we_out;
  logic [ADDR_W-1:0]     mem_addr_out;
  logic [DATA_W-1:0]     mem_wdata_out;
  logic [DATA_W/8-1:0]   mem_wr_mask_out;
  logic                  mem_ack_in;
  logic [DATA_W-1:0]     mem_rdata_in;

  logic                  busy_out;

  modport slave (
    input  if_req_in, if_addr_in,
    output if_gnt_out, if_rvalid_out, if_rdata_out,
    input  ls_req_in, ls_we_in, ls_misaligned_in, trap_taken_in,
    input  ls_addr_in, ls_wdata_in, ls_wr_mask_in,
    output ls_gnt_out, ls_rvalid_out, ls_rdata_out, ls_err_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wr_mask_out,
    input  mem_ack_in, mem_rdata_in,
    output busy_out
  );

  modport master (
    output if_req_in, if_addr_in,
    input  if_gnt_out, if_rvalid_out, if_rdata_out,
    output ls_req_in, ls_we_in, ls_misaligned_in, trap_taken_in,
    output ls_addr_in, ls_wdata_in, ls_wr_mask_in,
    input  ls_gnt_out, ls_rvalid_out, ls_rdata_out, ls_err_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wr_mask_out,
    output mem_ack_in, mem_rdata_in,
    input  busy_out
  );

endinterface

// File: rtl/msrv32_arb_starve_ctr.sv
// Counts consecutive LS launches while fetch is waiting; force_if_o asks the
// arbiter to serve fetch next. Used only in the MSRV32_ARB_FAIRNESS_EN build.
module msrv32_arb_starve_ctr import msrv32_pkg::*; #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic if_req_i,
  input  logic if_launch_i,
  input  logic ls_launch_i,
  output logic force_if_o
);
  localparam int unsigned     CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_launch_i || !if_req_i) begin
      cnt_d = '0;
    end else if (ls_launch_i && cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign force_if_o = (cnt_q == LIMIT);

endmodule

// File: rtl/msrv32_mem_arbiter.sv
// Memory-port arbiter: one bus transaction at a time between fetch and load/store.
// Optional build macro: MSRV32_ARB_FAIRNESS_EN (bounded LS priority over fetch).
module msrv32_mem_arbiter import msrv32_pkg::*; #(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                ms_riscv32_mp_clk_in,
  input  logic                ms_riscv32_mp_rst_n_in,
  msrv32_mem_arbiter_if.slave bus
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic [1:0]        state_q, state_d;
  logic              if_gnt_q, if_gnt_d, if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              ls_gnt_q, ls_gnt_d, ls_rvalid_q, ls_rvalid_d, ls_err_q, ls_err_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_mask_q, mem_mask_d;

  logic idle, ls_ok, ls_drop, if_launch, ls_launch, force_if;

  // A trap holds LS entirely (neither launched nor dropped) until it clears.
  assign idle      = (state_q == IDLE);
  assign ls_ok     = bus.ls_req_in & ~bus.ls_misaligned_in & ~bus.trap_taken_in;
  assign ls_drop   = idle & bus.ls_req_in & bus.ls_misaligned_in & ~bus.trap_taken_in;
  assign if_launch = idle & bus.if_req_in & (force_if | ~ls_ok);
  assign ls_launch = idle & ls_ok & ~if_launch;

`ifdef MSRV32_ARB_FAIRNESS_EN
  msrv32_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_ctr (
    .clk_i       (ms_riscv32_mp_clk_in),
    .rst_ni      (ms_riscv32_mp_rst_n_in),
    .if_req_i    (bus.if_req_in),
    .if_launch_i (if_launch),
    .ls_launch_i (ls_launch),
    .force_if_o  (force_if)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_if            = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    if_gnt_d    = if_launch;
    ls_gnt_d    = ls_drop | ls_launch;
    ls_err_d    = ls_drop;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    case (state_q)
      IDLE: begin
        if (if_launch) begin
          state_d     = IF_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr_in;
          mem_wdata_d = '0;
          mem_mask_d  = '0;
        end else if (ls_launch) begin
          state_d     = LS_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ls_we_in;
          mem_addr_d  = bus.ls_addr_in;
          mem_wdata_d = bus.ls_wdata_in;
          mem_mask_d  = bus.ls_wr_mask_in;
        end
      end
      IF_WAIT: begin
        if (bus.mem_ack_in) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata_in;
        end
      end
      LS_WAIT: begin
        if (bus.mem_ack_in) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = mem_we_q ? '0 : bus.mem_rdata_in;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q     <= IDLE;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_gnt_q    <= ls_gnt_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_err_q    <= ls_err_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
    end
  end

  assign bus.if_gnt_out      = if_gnt_q;
  assign bus.if_rvalid_out   = if_rvalid_q;
  assign bus.if_rdata_out    = if_rdata_q;
  assign bus.ls_gnt_out      = ls_gnt_q;
  assign bus.ls_rvalid_out   = ls_rvalid_q;
  assign bus.ls_rdata_out    = ls_rdata_q;
  assign bus.ls_err_out      = ls_err_q;
  assign bus.mem_req_out     = mem_req_q;
  assign bus.mem_we_out      = mem_we_q;
  assign bus.mem_addr_out    = mem_addr_q;
  assign bus.mem_wdata_out   = mem_wdata_q;
  assign bus.mem_wr_mask_out = mem_mask_q;
  assign bus.busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_msrv32_mem_arbiter.sv
// Bench for msrv32_mem_arbiter: directed scenarios plus randomized request
// episodes, checked against a transaction-level requester/memory model.
module tb_msrv32_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msrv32_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  msrv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .bus                    (bus)
  );

  int checks = 0;
  int errors = 0;

  // requester model
  bit          if_pend, ls_pend, ls_we, ls_mis, ls_repeat;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_mask;
  // memory model: one outstanding transaction
  bit          mem_busy, mem_hold, ack_real, ack_we, owner, txn_we;
  logic [31:0] txn_addr, txn_wdata, ack_data;
  logic [3:0]  txn_mask;
  int unsigned mem_cnt, lat_max, trap_left;
  logic [31:0] rq[$];
  string       log;
  int          cyc, if_rv_cnt, ls_rv_cnt, ls_gnt_cyc, trap_drop_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_s(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".if_gnt"},   bus.if_gnt_out, 0);
    check({tag, ".if_rv"},    bus.if_rvalid_out, 0);
    check({tag, ".if_rdata"}, bus.if_rdata_out, 0);
    check({tag, ".ls_gnt"},   bus.ls_gnt_out, 0);
    check({tag, ".ls_rv"},    bus.ls_rvalid_out, 0);
    check({tag, ".ls_rdata"}, bus.ls_rdata_out, 0);
    check({tag, ".ls_err"},   bus.ls_err_out, 0);
    check({tag, ".mem_req"},  bus.mem_req_out, 0);
    check({tag, ".mem_we"},   bus.mem_we_out, 0);
    check({tag, ".mem_addr"}, bus.mem_addr_out, 0);
    check({tag, ".mem_wd"},   bus.mem_wdata_out, 0);
    check({tag, ".mem_mask"}, bus.mem_wr_mask_out, 0);
    check({tag, ".busy"},     bus.busy_out, 0);
  endtask

  task automatic start_txn(input bit who, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] m);
    check("launch_while_busy", mem_busy, 0);
    mem_busy = 1; owner = who; txn_we = we; txn_addr = a; txn_wdata = wd; txn_mask = m;
    mem_cnt = $urandom_range(lat_max, 0);
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_addr = a; bus.if_addr_in = a; bus.if_req_in = 1; if_pend = 1;
  endtask

  task automatic issue_ls(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] m, input bit mis);
    ls_we = we; ls_addr = a; ls_wdata = wd; ls_mask = m; ls_mis = mis;
    bus.ls_we_in = we; bus.ls_addr_in = a; bus.ls_wdata_in = wd;
    bus.ls_wr_mask_in = m; bus.ls_misaligned_in = mis;
    bus.ls_req_in = 1; ls_pend = 1;
  endtask

  // One clock: observe DUT outputs just after the edge, update the model, drive inputs.
  task automatic tick();
    bit exp_ifrv, exp_lsrv;
    @(posedge clk); #1;
    cyc++;
    exp_ifrv = ack_real && (owner == 0);
    exp_lsrv = ack_real && (owner == 1);
    check("if_rvalid", bus.if_rvalid_out, exp_ifrv);
    check("ls_rvalid", bus.ls_rvalid_out, exp_lsrv);
    if (exp_ifrv) begin check("if_rdata", bus.if_rdata_out, ack_data); if_rv_cnt++; end
    if (exp_lsrv) begin check("ls_rdata", bus.ls_rdata_out, ack_we ? 32'h0 : ack_data); ls_rv_cnt++; end
    if (ack_real) mem_busy = 0;
    ack_real = 0;
    bus.mem_ack_in = 0;
    if (bus.ls_gnt_out) begin
      check("ls_gnt_expected", ls_pend, 1);
      check("ls_err", bus.ls_err_out, ls_mis);
      ls_gnt_cyc = cyc;
      if (ls_mis) log = {log, "E"};
      else begin log = {log, "L"}; start_txn(1, ls_we, ls_addr, ls_wdata, ls_mask); end
      if (!ls_repeat) begin ls_pend = 0; bus.ls_req_in = 0; end
    end else begin
      check("ls_err_idle", bus.ls_err_out, 0);
    end
    if (bus.if_gnt_out) begin
      check("if_gnt_expected", if_pend, 1);
      log = {log, "I"};
      start_txn(0, 0, if_addr, 0, 0);
      if_pend = 0; bus.if_req_in = 0;
    end
    check("busy", bus.busy_out, mem_busy);
    check("mem_req", bus.mem_req_out, mem_busy);
    if (mem_busy) begin
      check("mem_we", bus.mem_we_out, txn_we);
      check("mem_addr", bus.mem_addr_out, txn_addr);
      if (owner) begin
        check("mem_wdata", bus.mem_wdata_out, txn_wdata);
        check("mem_mask", bus.mem_wr_mask_out, txn_mask);
      end
      if (mem_cnt == 0 && !mem_hold) begin
        ack_data = (rq.size() != 0) ? rq.pop_front() : $urandom;
        bus.mem_ack_in = 1; bus.mem_rdata_in = ack_data;
        ack_real = 1; ack_we = txn_we;
      end else if (mem_cnt != 0) begin
        mem_cnt--;
      end
    end else begin
      // stray acks while idle must be ignored
      bus.mem_ack_in = ($urandom_range(3, 0) == 0);
      bus.mem_rdata_in = $urandom;
    end
    if (trap_left > 0) begin
      trap_left--;
      if (trap_left == 0) begin bus.trap_taken_in = 0; trap_drop_cyc = cyc; end
    end
  endtask

  task automatic run_until_idle(input string tag, input int unsigned bound);
    int unsigned n = 0;
    while ((if_pend || ls_pend || mem_busy || ack_real) && n < bound) begin tick(); n++; end
    check(tag, (if_pend || ls_pend || mem_busy || ack_real), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp;
    int    n;
    bus.if_req_in = 0; bus.if_addr_in = 0; bus.ls_req_in = 0; bus.ls_we_in = 0;
    bus.ls_misaligned_in = 0; bus.trap_taken_in = 0; bus.ls_addr_in = 0;
    bus.ls_wdata_in = 0; bus.ls_wr_mask_in = 0; bus.mem_ack_in = 0; bus.mem_rdata_in = 0;
    lat_max = 0;

    // reset state
    @(posedge clk); @(posedge clk); #1;
    check_zero("rst_init");
    rst_n = 1;

    // reset in the middle of LS_WAIT
    mem_hold = 1;
    issue_ls(1, 32'h0000_0080, 32'h1234_5678, 4'hf, 0);
    repeat (3) tick();
    check("rst_mid_busy_before", bus.busy_out, 1);
    #2 rst_n = 0;
    #1 check_zero("rst_mid");
    mem_hold = 0; mem_busy = 0; ack_real = 0; ls_pend = 0; if_pend = 0;
    bus.ls_req_in = 0; bus.mem_ack_in = 0;
    @(posedge clk); #3 rst_n = 1;

    // single fetch, zero-wait memory
    log = ""; if_rv_cnt = 0;
    rq.push_back(32'hDEAD_BEEF);
    issue_if(32'h0000_0100);
    tick();
    check_s("fetch_gnt_n1", log, "I");
    check("fetch_addr", bus.mem_addr_out, 32'h100);
    tick();
    check("fetch_rvalid_n2", if_rv_cnt, 1);
    check("fetch_rdata", bus.if_rdata_out, 32'hDEAD_BEEF);
    tick();

    // simultaneous IF and store: store goes first
    log = ""; ls_rv_cnt = 0;
    issue_ls(1, 32'h0000_0200, 32'h55, 4'b0011, 0);
    issue_if(32'h0000_0300);
    run_until_idle("store_done", 20);
    check_s("store_first", log, "LI");
    check("store_rv_cnt", ls_rv_cnt, 1);

    // misaligned load dropped without a bus cycle
    log = "";
    issue_ls(0, 32'h0000_0201, 0, 4'hf, 1);
    tick();
    check_s("mis_drop", log, "E");
    tick();
    check("mis_no_bus", bus.mem_req_out, 0);
    run_until_idle("mis_done", 10);

    // trap holds LS while IF proceeds
    log = "";
    bus.trap_taken_in = 1; trap_left = 6;
    issue_ls(0, 32'h0000_0400, 0, 4'hf, 0);
    issue_if(32'h0000_0500);
    run_until_idle("trap_done", 30);
    check_s("trap_order", log, "IL");
    check("trap_ls_after_drop", (ls_gnt_cyc > trap_drop_cyc), 1);

    // continuous LS + IF pressure
    log = ""; lat_max = 1; ls_repeat = 1;
    issue_ls(0, 32'h0000_0600, 0, 4'hf, 0);
    issue_if(32'h0000_0700);
    n = 0;
    while (log.len() < 5 && n < 80) begin tick(); n++; end
    ls_repeat = 0; bus.ls_req_in = 0; ls_pend = 0;
    run_until_idle("fair_done", 60);
`ifdef MSRV32_ARB_FAIRNESS_EN
    exp = "LLLLI";
`else
    exp = "LLLLL";
`endif
    check_s("fair_pattern", log.substr(0, 4), exp);

    // randomized episodes
    lat_max = 3;
    for (int e = 0; e < 40; e++) begin
      logic [31:0] a1, a2, wd;
      bit          di, dl, we, mis, tr;
      repeat ($urandom_range(2, 0)) tick();
      di  = ($urandom_range(9, 0) < 7);
      dl  = ($urandom_range(9, 0) < 7);
      if (!di && !dl) dl = 1;
      we  = $urandom_range(1, 0);
      mis = dl && ($urandom_range(5, 0) == 0);
      tr  = !mis && ($urandom_range(3, 0) == 0);
      a1 = $urandom; a2 = $urandom; wd = $urandom;
      log = "";
      if (tr) begin bus.trap_taken_in = 1; trap_left = $urandom_range(6, 1); end
      if (dl) issue_ls(we, mis ? {a2[31:2], 2'b01} : {a2[31:2], 2'b00}, wd, 4'($urandom), mis);
      if (di) issue_if({a1[31:2], 2'b00});
      if (mis)           exp = di ? "EI" : "E";
      else if (dl && di) exp = tr ? "IL" : "LI";
      else               exp = dl ? "L" : "I";
      run_until_idle("rand_done", 60);
      while (trap_left > 0) tick();
      check_s("rand_order", log, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
